// File: rtl/isp_blc_gain.sv
// isp_blc_gain: Bayer black level subtraction plus rounded, saturating digital gain, with frame-shadowed config.
// Define ISP_BLC_GAIN_STAT_EN to add the per-frame clipped-pixel counter (clip_cnt, clip_cnt_valid).
module isp_blc_gain #(
    parameter int BITS      = 8,
    parameter int GAIN_BITS = 12,
    parameter int GAIN_FRAC = 8
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           bayer,
    input  logic [BITS-1:0]      black_b,
    input  logic [BITS-1:0]      black_gb,
    input  logic [BITS-1:0]      black_gr,
    input  logic [BITS-1:0]      black_r,
    input  logic [GAIN_BITS-1:0] norm_gain,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic [BITS-1:0]      in_raw,
    output logic                 out_href,
    output logic                 out_vsync,
    output logic [BITS-1:0]      out_raw
`ifdef ISP_BLC_GAIN_STAT_EN
    ,
    output logic [31:0]          clip_cnt,
    output logic                 clip_cnt_valid
`endif
);
    localparam int PW   = BITS + GAIN_BITS;
    localparam int SW   = PW - GAIN_FRAC + 1;
    localparam int MAXV = (1 << BITS) - 1;
    localparam logic [PW:0] HALF = (PW+1)'(1) << (GAIN_FRAC - 1);

    logic                 vs_d, href_d, odd_pix, odd_line, vs_rise;
    logic                 sh_en;
    logic [1:0]           sh_bayer, ch;
    logic [BITS-1:0]      sh_b, sh_gb, sh_gr, sh_r, black_sel;
    logic [GAIN_BITS-1:0] sh_gain;

    logic                 href1, vs1, en1, href2, vs2, en2;
    logic [BITS-1:0]      raw1, blk1, diff2, sat_val;
    logic [GAIN_BITS-1:0] gain1, gain2;
    logic [PW-1:0]        prod;
    logic [PW:0]          rounded;
    logic [SW-1:0]        scaled;

    always_comb begin
        vs_rise   = in_vsync & ~vs_d;
        ch        = {odd_line ^ sh_bayer[1], odd_pix ^ sh_bayer[0]};
        black_sel = ch == 2'd0 ? sh_b : ch == 2'd1 ? sh_gb : ch == 2'd2 ? sh_gr : sh_r;
        prod      = PW'(diff2) * PW'(gain2);
        rounded   = {1'b0, prod} + HALF;
        scaled    = SW'(rounded >> GAIN_FRAC);
        sat_val   = scaled > SW'(MAXV) ? '1 : scaled[BITS-1:0];
    end

    // Config is only sampled on the vsync rising edge so a frame never sees a partial update.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d     <= 1'b0;
            href_d   <= 1'b0;
            odd_pix  <= 1'b0;
            odd_line <= 1'b0;
            sh_en    <= 1'b0;
            sh_bayer <= '0;
            sh_b     <= '0;
            sh_gb    <= '0;
            sh_gr    <= '0;
            sh_r     <= '0;
            sh_gain  <= '0;
        end else begin
            vs_d     <= in_vsync;
            href_d   <= in_href;
            odd_pix  <= in_href ? ~odd_pix : 1'b0;
            odd_line <= in_vsync ? 1'b0 : (href_d & ~in_href) ? ~odd_line : odd_line;
            if (vs_rise) begin
                sh_en    <= enable;
                sh_bayer <= bayer;
                sh_b     <= black_b;
                sh_gb    <= black_gb;
                sh_gr    <= black_gr;
                sh_r     <= black_r;
                sh_gain  <= norm_gain;
            end
        end
    end

    // Bypass rides the same pipe with a zero black level; enable and gain travel with each pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            href1     <= 1'b0;
            vs1       <= 1'b0;
            en1       <= 1'b0;
            raw1      <= '0;
            blk1      <= '0;
            gain1     <= '0;
            href2     <= 1'b0;
            vs2       <= 1'b0;
            en2       <= 1'b0;
            diff2     <= '0;
            gain2     <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_raw   <= '0;
        end else begin
            href1     <= in_href;
            vs1       <= in_vsync;
            en1       <= sh_en;
            raw1      <= in_raw;
            blk1      <= sh_en ? black_sel : '0;
            gain1     <= sh_gain;
            href2     <= href1;
            vs2       <= vs1;
            en2       <= en1;
            diff2     <= raw1 > blk1 ? raw1 - blk1 : '0;
            gain2     <= gain1;
            out_href  <= href2;
            out_vsync <= vs2;
            out_raw   <= !href2 ? '0 : en2 ? sat_val : diff2;
        end
    end

`ifdef ISP_BLC_GAIN_STAT_EN
    logic [31:0] clip_run;
    logic        clip_now;

    always_comb clip_now = sh_en & in_href & (in_raw <= black_sel);

    always_ff @(posedge pclk) begin
        if (rst) begin
            clip_run       <= '0;
            clip_cnt       <= '0;
            clip_cnt_valid <= 1'b0;
        end else if (vs_rise) begin
            clip_cnt       <= clip_run;
            clip_run       <= 32'(clip_now);
            clip_cnt_valid <= 1'b1;
        end else begin
            clip_cnt_valid <= 1'b0;
            if (clip_now && !(&clip_run))
                clip_run <= clip_run + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_isp_blc_gain.sv
// tb_isp_blc_gain: randomized and directed scoreboard bench for isp_blc_gain against a frame-level reference model.
module tb_isp_blc_gain;
    localparam int GAIN_FRAC = 8;

    typedef struct {
        bit h;
        bit v;
        int raw;
    } exp_t;

    logic        pclk = 1'b0, rst = 1'b0, enable = 1'b0, in_href = 1'b0, in_vsync = 1'b0;
    logic [1:0]  bayer = '0;
    logic [7:0]  black_b = '0, black_gb = '0, black_gr = '0, black_r = '0, in_raw = '0;
    logic [11:0] norm_gain = '0;
    logic        out_href, out_vsync;
    logic [7:0]  out_raw;
`ifdef ISP_BLC_GAIN_STAT_EN
    logic [31:0] clip_cnt;
    logic        clip_cnt_valid;
`endif

    isp_blc_gain dut (
        .pclk(pclk), .rst(rst), .enable(enable), .bayer(bayer),
        .black_b(black_b), .black_gb(black_gb), .black_gr(black_gr), .black_r(black_r),
        .norm_gain(norm_gain), .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw)
`ifdef ISP_BLC_GAIN_STAT_EN
        , .clip_cnt(clip_cnt), .clip_cnt_valid(clip_cnt_valid)
`endif
    );

    always #5 pclk = ~pclk;

    // Colour at (row parity, column parity) for each Bayer order: 0=B 1=Gb 2=Gr 3=R.
    int pat [4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}};

    bit   c_en;
    int   c_bayer, c_gain;
    int   c_blk [4];
    bit   m_en, m_pv, m_ph;
    int   m_bayer, m_gain, m_x, m_y, m_clip;
    int   m_blk [4];
    exp_t q[$];
    int   sq[$];
    int   checks = 0, passed = 0;

    task automatic step(input bit r, input bit h, input bit v, input int raw, input int want);
        int c, blk, res;
        bit clipped;
        @(posedge pclk);
        #1;
        rst = r; in_href = h; in_vsync = v; in_raw = 8'(raw);
        enable = c_en; bayer = 2'(c_bayer); norm_gain = 12'(c_gain);
        black_b = 8'(c_blk[0]); black_gb = 8'(c_blk[1]); black_gr = 8'(c_blk[2]); black_r = 8'(c_blk[3]);
        if (r) begin
            if (q.size() >= 2) begin
                q[q.size()-1] = '{0, 0, 0};
                q[q.size()-2] = '{0, 0, 0};
            end
            q.push_back('{0, 0, 0});
            m_en = 0; m_bayer = 0; m_gain = 0; m_blk = '{0, 0, 0, 0};
            m_pv = 0; m_ph = 0; m_x = 0; m_y = 0; m_clip = 0;
            return;
        end
        c = pat[m_bayer][(m_y % 2) * 2 + (m_x % 2)];
        blk = m_blk[c];
        if (!m_en) res = raw;
        else begin
            res = raw > blk ? raw - blk : 0;
            res = (res * m_gain + (1 << (GAIN_FRAC - 1))) >> GAIN_FRAC;
            if (res > 255) res = 255;
        end
        if (!h) res = 0;
        q.push_back('{h, v, (want >= 0 && h) ? want : res});
        clipped = m_en && h && raw <= blk;
        if (v && !m_pv) begin
            sq.push_back(m_clip);
            m_clip = clipped ? 1 : 0;
            m_en = c_en; m_bayer = c_bayer; m_gain = c_gain; m_blk = c_blk;
        end else if (clipped) m_clip++;
        if (h) m_x++; else m_x = 0;
        if (v) m_y = 0; else if (m_ph && !h) m_y++;
        m_ph = h; m_pv = v;
    endtask

    task automatic px(input int raw, input int want);
        step(0, 1, 0, raw, want);
    endtask

    task automatic bl(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, int'($urandom_range(0, 255)), -1);
    endtask

    task automatic vs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, int'($urandom_range(0, 255)), -1);
    endtask

    task automatic cfg(input bit en, input int b, input int k0, input int k1, input int k2, input int k3, input int g);
        c_en = en; c_bayer = b; c_gain = g; c_blk = '{k0, k1, k2, k3};
    endtask

    task automatic scramble();
        c_en = $urandom_range(0, 4) != 0;
        c_bayer = $urandom_range(0, 3);
        c_gain = $urandom_range(0, 3) == 0 ? 256 : int'($urandom_range(0, 4095));
        for (int i = 0; i < 4; i++) c_blk[i] = $urandom_range(0, 7) == 0 ? 255 : int'($urandom_range(0, 80));
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (q.size() >= 4) begin
            e = q.pop_front();
            checks++;
            if (out_href === e.h && out_vsync === e.v && out_raw === 8'(e.raw)) passed++;
            else $display("FAIL pixel t=%0t got href=%b vsync=%b raw=%0d expected href=%b vsync=%b raw=%0d",
                          $time, out_href, out_vsync, out_raw, e.h, e.v, e.raw);
        end
    end

`ifdef ISP_BLC_GAIN_STAT_EN
    always @(negedge pclk) begin
        int s;
        if (clip_cnt_valid) begin
            checks++;
            if (sq.size() == 0) $display("FAIL clip_pulse t=%0t got unexpected clip_cnt_valid expected none", $time);
            else begin
                s = sq.pop_front();
                if (clip_cnt === 32'(s)) passed++;
                else $display("FAIL clip_cnt t=%0t got %0d expected %0d", $time, clip_cnt, s);
            end
        end
    end
`endif

    initial begin
        cfg(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 'h55, 0);
        px('h55, 'h55); bl(2);
        vs(2); bl(1);
        for (int i = 0; i < 4; i++) px('h55, 'h55);
        bl(2);

        cfg(1, 0, 16, 17, 18, 19, 256);
        vs(2); bl(2); px(100, 84); px(100, 83); bl(2); px(100, 82); px(100, 81); bl(2);
        c_bayer = 3;
        vs(2); bl(2); px(100, 81); px(100, 82); bl(2);

        cfg(1, 0, 16, 17, 18, 19, 256);
        vs(2); bl(1); px(10, 0); px(50, 33); px(16, 0); bl(2);

        cfg(1, 0, 16, 16, 16, 16, 272);
        vs(2); bl(1); px(255, 254); bl(2);
        c_gain = 512;
        vs(2); bl(1); px(200, 255); bl(2);

        cfg(1, 0, 16, 17, 18, 19, 256);
        vs(2); bl(1); px(100, 84); px(50, 33);
        c_blk[0] = 40;
        px(100, 84); bl(2); px(100, 82); bl(2);
        step(0, 1, 1, 100, 84); vs(1); bl(1); px(100, 60); bl(2);

        cfg(1, 0, 16, 16, 16, 16, 256);
        vs(2); bl(1);
        for (int i = 0; i < 5; i++) px(5, 0);
        bl(2); vs(2); bl(1);
        for (int i = 0; i < 4; i++) px(100, 84);
        bl(2); vs(2); bl(2);

        for (int f = 0; f < 25; f++) begin
            scramble();
            vs(int'($urandom_range(1, 3))); bl(int'($urandom_range(1, 3)));
            for (int l = 0, nl = int'($urandom_range(2, 5)); l < nl; l++) begin
                for (int p = 0, np = int'($urandom_range(1, 10)); p < np; p++) begin
                    if ($urandom_range(0, 7) == 0) scramble();
                    px(int'($urandom_range(0, 255)), -1);
                end
                bl(int'($urandom_range(1, 3)));
            end
        end

        scramble();
        vs(2); bl(1);
        for (int i = 0; i < 5; i++) px(int'($urandom_range(0, 255)), -1);
        step(1, 1, 0, 77, 0); step(1, 1, 0, 77, 0);
        for (int i = 0; i < 6; i++) px(int'($urandom_range(0, 255)), -1);
        bl(2);
        for (int i = 0; i < 3; i++) px(int'($urandom_range(0, 255)), -1);
        bl(2); vs(2); bl(2);
        for (int i = 0; i < 4; i++) px(int'($urandom_range(0, 255)), -1);
        bl(2); vs(2); bl(6);

`ifdef ISP_BLC_GAIN_STAT_EN
        checks++;
        if (sq.size() == 0) passed++;
        else $display("FAIL clip_pending got %0d unreported frames expected 0", sq.size());
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/isp_blc_gain.md
Name: isp_blc_gain

Overview:
- Second-generation black level correction for the raw Bayer path. It sits directly after the sensor capture and ahead of demosaic.
- Subtracts a per-channel black level with a runtime-selectable Bayer order, then re-normalises with a fixed-point digital gain and saturates the result.
- Configuration is shadowed and takes effect only at frame boundaries. The datapath is a fixed 3-stage pipeline with aligned sync signals.

Parameters:
- BITS, 8: raw pixel and black-level width.
- GAIN_BITS, 12: width of the unsigned normalisation gain.
- GAIN_FRAC, 8: fractional bits of the gain (gain 2^GAIN_FRAC = 1.0). Legal range is 1..GAIN_BITS.

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = correct, 0 = bypass.
- bayer  in  2  0:BGGR 1:GBRG 2:GRBG 3:RGGB.
- black_b, black_gb, black_gr, black_r  in  BITS each  per-channel black levels.
- norm_gain  in  GAIN_BITS  post-subtraction gain.
- in_href  in  1  line valid.
- in_vsync  in  1  frame sync, active high.
- in_raw  in  BITS  pixel value.
- out_href  out  1  in_href delayed 3 cycles.
- out_vsync  out  1  in_vsync delayed 3 cycles.
- out_raw  out  BITS  corrected pixel.

Behaviour:
- Reset:
  - All outputs, pipeline registers, phase flags and shadow registers go to 0.
  - Shadow enable=0 means the block is in bypass until the first vsync edge.
- Shadow registers:
  - enable, bayer, the four blacks and norm_gain are captured on the cycle where in_vsync rises (in_vsync=1 and the registered previous vsync=0).
  - A pixel presented on that same cycle uses the pre-update values.
  - Port changes mid-frame have no effect until the next rising edge.
- Phase tracking:
  - odd_pix is cleared while in_href=0 and toggles every cycle in_href=1.
  - odd_line is cleared while in_vsync=1 and toggles on each in_href falling edge.
- Channel:
  - ch = {odd_line ^ bayer[1], odd_pix ^ bayer[0]}, where 00=B, 01=Gb, 10=Gr, 11=R.
- S1 (registered): in_raw, the selected black level, and the href/vsync pipeline bit.
- S2 (registered): diff = raw > black ? raw - black : 0. raw equal to black gives 0.
- S3 (registered):
  - prod = diff * gain, full width BITS+GAIN_BITS.
  - Round by adding 2^(GAIN_FRAC-1), then shift right by GAIN_FRAC.
  - Saturate to 2^BITS-1.
- Bypass: when shadow enable=0, out_raw equals in_raw from 3 cycles earlier, with no subtraction or gain.
- Blanking: out_raw is forced to 0 on every cycle where out_href=0.
- Latency: exactly 3 cycles for data, href and vsync in all modes. There is no backpressure.
- Reset asserted mid-frame:
  - The pipeline flushes to 0 on the next edge.
  - Phases restart; the first line after reset is treated as even.

Optional Feature:
- Macro: ISP_BLC_GAIN_STAT_EN.
- With the macro defined, two extra ports are added:
  - clip_cnt  out  32: count of href-valid pixels in the previous frame with raw <= black (clipped to 0). The counter saturates at 0xFFFFFFFF.
  - clip_cnt_valid  out  1: one-cycle pulse on the vsync rising edge, when the running count is copied to clip_cnt and cleared.
- Both registers reset to 0.
- Without the macro, these ports and the counter logic do not exist.

Test Plan:
1. Reset, then drive in_raw=0x55 with href=1 → out_raw=0, out_href=0. After the first vsync edge with enable=0, out_raw=0x55 appears 3 cycles after input.
2. BGGR, blacks 16/17/18/19, gain=256, enable=1, line0 pixels 100,100 → 84,83; line1 pixels 100,100 → 82,81. Repeat with bayer=3: line0 → 81,82.
3. Clip: black_b=16, B pixels 10 and 16 → out_raw 0 and 0.
4. Gain: black 16, gain 272, in 255 → 254. Gain 512, in 200 → saturates to 255.
5. Shadow: set black_b=40 mid-frame → B pixel 100 still gives 84 until after the next vsync rise, then gives 60. Also drive a pixel on the vsync-rise cycle → it uses the old value.
6. With ISP_BLC_GAIN_STAT_EN defined: 5 clipped pixels in a frame → clip_cnt=5 and a one-cycle clip_cnt_valid pulse at the next vsync rise. A following clean frame → clip_cnt=0.
